// File: rtl/fetch_queue.sv
// Instruction fetch front-end: one-outstanding sequential fetch into a small
// first-word-fall-through FIFO, flushed and restarted by a redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_gnt,
  input  logic                         imem_rvalid,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   inflight_pc_reg, inflight_pc_next;
  logic          inflight_reg, inflight_next;
  logic          drop_reg, drop_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [CW:0] pending;
  logic        grant, resp, push, pop;

  // Space check counts the outstanding request but never credits a same-cycle pop.
  assign pending   = {1'b0, count_reg} + (CW+1)'(inflight_reg);
  assign imem_req  = !rst && !redirect_valid && (!inflight_reg || imem_rvalid)
                     && (pending < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_reg;
  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && inflight_reg;
  assign push      = resp && !drop_reg && !redirect_valid;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg] : 32'h0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign occupancy = count_reg;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_pc_next = inflight_pc_reg;
    inflight_next    = inflight_reg;
    drop_next        = drop_reg;
    count_next       = count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    if (redirect_valid) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      // A response arriving now is simply discarded; one still to come must be dropped.
      inflight_next = inflight_reg && !imem_rvalid;
      drop_next     = inflight_reg && !imem_rvalid;
    end else begin
      if (grant) begin
        fetch_pc_next    = fetch_pc_reg + 32'd4;
        inflight_next    = 1'b1;
        inflight_pc_next = fetch_pc_reg;
      end else if (resp) begin
        inflight_next = 1'b0;
      end
      if (resp && drop_reg) drop_next = 1'b0;
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_pc_reg <= 32'h0;
      inflight_reg    <= 1'b0;
      drop_reg        <= 1'b0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_pc_reg <= inflight_pc_next;
      inflight_reg    <= inflight_next;
      drop_reg        <= drop_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized phase, all
// checked against a queue-based model of the fetch/FIFO behaviour.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic [CW-1:0] occupancy;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Behavioural model state
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_inflight;
  bit          m_drop;

  // Memory responder: response arrives 'lat' cycles after a grant
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = RESET_PC;
    m_ipc      = 32'h0;
    m_inflight = 1'b0;
    m_drop     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'h0);
    chk({tag, "_addr"},  imem_addr, RESET_PC);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_pc"},    out_pc, 32'h0);
    chk({tag, "_instr"}, out_instr, 32'h0);
    chk({tag, "_occ"},   32'(occupancy), 32'h0);
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit ready,
                      input bit gnt, input bit spur);
    bit          rv, ereq, granted;
    logic [31:0] rd, gaddr;
    @(negedge clk);
    rv = (pend_cnt == 1);
    rd = pend_addr ^ 32'hA5A5_0000;
    if (pend_cnt == 0 && spur) begin
      rv = 1'b1;
      rd = $urandom;
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ready;
    imem_gnt       = gnt;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    #1;
    ereq = !redir && (!m_inflight || rv) && ((m_q.size() + int'(m_inflight)) < DEPTH);
    chk("imem_req",  32'(imem_req), 32'(ereq));
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("out_pc",    out_pc,    (m_q.size() != 0) ? m_q[0].pc    : 32'h0);
    chk("out_instr", out_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
    chk("occ_bound", 32'(int'(occupancy) <= DEPTH), 32'h1);
    granted = imem_req && imem_gnt;
    gaddr   = imem_addr;
    if (redir) begin
      m_q.delete();
      m_drop     = m_inflight && !rv;
      m_inflight = m_inflight && !rv;
      m_pc       = {rpc[31:2], 2'b00};
    end else begin
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      if (rv && m_inflight) begin
        if (m_drop) m_drop = 1'b0;
        else        m_q.push_back('{pc: m_ipc, instr: rd});
        m_inflight = 1'b0;
      end
      if (ereq && gnt) begin
        m_inflight = 1'b1;
        m_ipc      = m_pc;
        m_pc       = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    if (granted) begin
      pend_cnt  = lat;
      pend_addr = gaddr;
    end else if (pend_cnt != 0) begin
      pend_cnt--;
    end
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Streaming fetch with always-grant and always-ready
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);

    // Decode stalled: FIFO fills, requests stop; then drain in order
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    chk("full_occ", 32'(occupancy), DEPTH);
    chk("full_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0);

    // Grant refusal at a known address
    step(1, 32'h10, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("hold_addr", imem_addr, 32'h10);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0);

    // Redirect while a slow request is outstanding and two entries are queued
    lat = 2;
    step(1, 32'h300, 0, 1, 0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(0, 0, 0, 1, 0);
      hit = (m_q.size() == 2) && m_inflight && (pend_cnt == 2);
    end
    chk("redir_setup_timeout", 32'(hit), 32'h1);
    step(1, 32'h103, 1, 1, 0);
    chk("redir_drop", 32'(m_drop), 32'h1);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(0, 0, 1, 1, 0);
      #1 hit = out_valid;
    end
    chk("redir_first_valid", 32'(hit), 32'h1);
    chk("redir_first_pc", out_pc, 32'h100);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0);

    // Simultaneous push and pop at occupancy 2
    lat = 1;
    step(1, 32'h200, 0, 1, 0);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(0, 0, 0, 1, 0);
      hit = (m_q.size() == 2);
    end
    chk("pushpop_setup_timeout", 32'(hit), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 0);
      chk("pushpop_occ", 32'(occupancy), 32'h2);
    end

    // Address wrap from the top of the address space
    step(1, 32'hFFFF_FFF6, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0);

    // Reset pulsed with a request outstanding; its trailing response is ignored
    step(0, 0, 1, 1, 0);
    chk("rst_setup_pend", 32'(pend_cnt), 32'h1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(0, 0, 1, 1, 0);
      #1 hit = out_valid;
    end
    chk("rst_first_valid", 32'(hit), 32'h1);
    chk("rst_first_pc", out_pc, RESET_PC);

    // Randomized phase: random grants, stalls, latencies, spurious rvalids, redirects
    for (int seg = 0; seg < 20; seg++) begin
      if (pend_cnt == 0) lat = $urandom_range(1, 2);
      for (int i = 0; i < 25; i++)
        step(($urandom_range(0, 15) == 0), $urandom, $urandom_range(0, 1),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
